// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the external memory bus between the fetch and
// memstage data requesters. Each transaction runs as address phase, then an
// optional write-data phase (stores) or a BEATS-long read fill (loads), and
// ends with a one-cycle done pulse to the owner.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transaction; arbitrate and capture the winning request
// ADDR   | address phase on the bus, waiting for bus_reqack
// WDATA  | store data phase on the bus, waiting for bus_reqack
// RESP   | collecting read beats, forwarding each accepted beat
// DONE   | done pulse visible to the owner; back to IDLE next cycle
module mem_port_arbiter #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fetch_req,
  input  logic [DATA_W-1:0]          fetch_addr,
  input  logic                       data_req,
  input  logic [DATA_W-1:0]          data_addr,
  input  logic                       data_we,
  input  logic [DATA_W-1:0]          data_wdata,
  output logic                       fetch_done,
  output logic                       data_done,
  output logic                       resp_valid,
  output logic                       resp_owner,
  output logic [$clog2(BEATS)-1:0]   resp_beat,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       bus_reqcyc,
  output logic [DATA_W-1:0]          bus_req,
  output logic [1:0]                 bus_reqtag,
  input  logic                       bus_reqack,
  input  logic                       bus_respcyc,
  input  logic [DATA_W-1:0]          bus_resp,
  output logic                       bus_respack
);

  localparam int BW = $clog2(BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                owner_q;       // 0 = fetch, 1 = data
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BW-1:0]       beat_q;
  logic                last_grant_q;  // 1 = data was granted last
  logic                bus_reqcyc_q;
  logic [DATA_W-1:0]   bus_req_q;     // doubles as the captured address
  logic [1:0]          bus_reqtag_q;
  logic                fetch_done_q;
  logic                data_done_q;

  logic                owner_d;
  logic                we_d;
  logic [DATA_W-1:0]   addr_d;
  logic                resp_fire;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    owner_d = data_req & (~fetch_req | ~last_grant_q);
    we_d    = owner_d & data_we;
    addr_d  = owner_d ? data_addr : fetch_addr;
  end

  // Response beats are only accepted and forwarded while collecting a fill.
  assign resp_fire   = (state_q == S_RESP) && bus_respcyc;
  assign bus_respack = resp_fire;
  assign resp_valid  = resp_fire;
  assign resp_owner  = resp_fire & owner_q;
  assign resp_beat   = resp_fire ? beat_q : '0;
  assign resp_data   = resp_fire ? bus_resp : '0;

  assign bus_reqcyc  = bus_reqcyc_q;
  assign bus_req     = bus_req_q;
  assign bus_reqtag  = bus_reqtag_q;
  assign fetch_done  = fetch_done_q;
  assign data_done   = data_done_q;

  // Transaction sequencer with registered bus request and done outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      beat_q       <= '0;
      last_grant_q <= 1'b1;
      bus_reqcyc_q <= 1'b0;
      bus_req_q    <= '0;
      bus_reqtag_q <= '0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_req || data_req) begin
            owner_q      <= owner_d;
            last_grant_q <= owner_d;
            we_q         <= we_d;
            wdata_q      <= data_wdata;
            bus_reqcyc_q <= 1'b1;
            bus_req_q    <= addr_d;
            bus_reqtag_q <= {we_d, owner_d};
            state_q      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus_reqack) begin
            if (we_q) begin
              bus_req_q <= wdata_q;
              state_q   <= S_WDATA;
            end else begin
              bus_reqcyc_q <= 1'b0;
              bus_req_q    <= '0;
              bus_reqtag_q <= '0;
              state_q      <= S_RESP;
            end
          end
        end
        S_WDATA: begin
          if (bus_reqack) begin
            bus_reqcyc_q <= 1'b0;
            bus_req_q    <= '0;
            bus_reqtag_q <= '0;
            fetch_done_q <= ~owner_q;
            data_done_q  <= owner_q;
            state_q      <= S_DONE;
          end
        end
        S_RESP: begin
          if (bus_respcyc) begin
            if (beat_q == BW'(BEATS - 1)) begin
              beat_q       <= '0;
              fetch_done_q <= ~owner_q;
              data_done_q  <= owner_q;
              state_q      <= S_DONE;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a bus responder model plus scoreboards of
// expected request phases, read beats and done pulses.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        data_req;
  logic [63:0] data_addr;
  logic        data_we;
  logic [63:0] data_wdata;
  logic        fetch_done;
  logic        data_done;
  logic        resp_valid;
  logic        resp_owner;
  logic [2:0]  resp_beat;
  logic [63:0] resp_data;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [1:0]  bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic        bus_respack;

  mem_port_arbiter #(.DATA_W(64), .BEATS(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .data_req    (data_req),
    .data_addr   (data_addr),
    .data_we     (data_we),
    .data_wdata  (data_wdata),
    .fetch_done  (fetch_done),
    .data_done   (data_done),
    .resp_valid  (resp_valid),
    .resp_owner  (resp_owner),
    .resp_beat   (resp_beat),
    .resp_data   (resp_data),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_respack (bus_respack)
  );

  typedef struct {
    logic        owner;
    int          beat;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    logic [63:0] v;
    logic [1:0]  tag;
  } req_t;

  typedef struct {
    logic owner;
    int   cyc;
  } done_t;

  beat_t exp_beats[$];
  req_t  exp_req[$];
  done_t exp_done[$];

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int done_cnt = 0;
  int exp_n = 0;
  int rd_n = 0;
  int last_beat = -1;

  // bus model knobs and state
  int       ack_wait = 0;
  logic [7:0] gap_mask = 8'h00;
  logic     stray_req = 1'b0;
  int       wait_cnt = 0;
  logic     responding = 1'b0;
  logic     gap_pending = 1'b0;
  int       rbeat = 0;
  int       cur_n = 0;
  logic     drove_beat = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc_cnt);
    end
  endtask

  function automatic logic [63:0] beat_data(input int n, input int b);
    return {n[31:0], 16'hBEA7, b[15:0]};
  endfunction

  task automatic push_load(input logic owner, input logic [63:0] addr, input int done_cyc, input logic with_done);
    req_t r;
    beat_t b;
    done_t d;
    r.v = addr;
    r.tag = {1'b0, owner};
    exp_req.push_back(r);
    for (int i = 0; i < 8; i++) begin
      b.owner = owner;
      b.beat = i;
      b.data = beat_data(exp_n, i);
      exp_beats.push_back(b);
    end
    exp_n++;
    if (with_done) begin
      d.owner = owner;
      d.cyc = done_cyc;
      exp_done.push_back(d);
    end
  endtask

  task automatic push_store(input logic [63:0] addr, input logic [63:0] wdata, input int done_cyc);
    req_t r;
    done_t d;
    r.tag = 2'b11;
    r.v = addr;
    exp_req.push_back(r);
    r.v = wdata;
    exp_req.push_back(r);
    d.owner = 1'b1;
    d.cyc = done_cyc;
    exp_done.push_back(d);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input int target);
    int budget;
    budget = 0;
    while (done_cnt < target && budget < 200) begin
      step();
      budget++;
    end
    if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {58'b0, bus_reqcyc, bus_respack, resp_valid, resp_owner, fetch_done, data_done}, 64'h0);
    chk({tag, "_req"}, bus_req, 64'h0);
    chk({tag, "_tag"}, {62'b0, bus_reqtag}, 64'h0);
    chk({tag, "_rdata"}, resp_data, 64'h0);
    chk({tag, "_rbeat"}, {61'b0, resp_beat}, 64'h0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc_cnt++;
    end
  end

  // Bus responder and output monitor: drives bus inputs for the current
  // cycle at the falling edge, then checks everything the DUT shows.
  initial begin
    bus_reqack = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus_reqack = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp = '0;
        responding = 1'b0;
        gap_pending = 1'b0;
        wait_cnt = 0;
        rbeat = 0;
        drove_beat = 1'b0;
      end else begin
        drove_beat = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp = '0;
        if (responding) begin
          if (gap_pending) begin
            gap_pending = 1'b0;
          end else begin
            bus_respcyc = 1'b1;
            bus_resp = beat_data(cur_n, rbeat);
            drove_beat = 1'b1;
            if (gap_mask[rbeat]) gap_pending = 1'b1;
            rbeat++;
            if (rbeat == 8) responding = 1'b0;
          end
        end else if (stray_req) begin
          bus_respcyc = 1'b1;
          bus_resp = 64'hBAD0_BAD0_BAD0_BAD0;
          stray_req = 1'b0;
        end

        bus_reqack = 1'b0;
        if (bus_reqcyc) begin
          if (exp_req.size() == 0) begin
            chk("req_unexpected", 64'(bus_req), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk("req_value", bus_req, exp_req[0].v);
            chk("req_tag", {62'b0, bus_reqtag}, {62'b0, exp_req[0].tag});
            if (wait_cnt < ack_wait) begin
              wait_cnt++;
            end else begin
              bus_reqack = 1'b1;
              wait_cnt = 0;
              if (!exp_req[0].tag[1]) begin
                responding = 1'b1;
                rbeat = 0;
                cur_n = rd_n;
                rd_n++;
              end
              void'(exp_req.pop_front());
            end
          end
        end

        #1;
        chk("respack", {63'b0, bus_respack}, {63'b0, drove_beat});
        chk("resp_valid", {63'b0, resp_valid}, {63'b0, drove_beat});
        if (resp_valid) begin
          if (exp_beats.size() == 0) begin
            chk("beat_unexpected", {61'b0, resp_beat}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            beat_t e;
            e = exp_beats.pop_front();
            chk("resp_owner", {63'b0, resp_owner}, {63'b0, e.owner});
            chk("resp_beat", {61'b0, resp_beat}, 64'(e.beat));
            chk("resp_data", resp_data, e.data);
            last_beat = int'(resp_beat);
          end
        end
        if (fetch_done || data_done) begin
          if (fetch_done && data_done) chk("done_both", 64'h1, 64'h0);
          if (exp_done.size() == 0) begin
            chk("done_unexpected", {62'b0, fetch_done, data_done}, 64'h0);
          end else begin
            done_t d;
            d = exp_done.pop_front();
            chk("done_owner", {63'b0, data_done}, {63'b0, d.owner});
            chk("done_cycle", 64'(cyc_cnt), 64'(d.cyc));
          end
          done_cnt++;
        end
      end
    end
  end

  initial begin
    int t0;
    int budget;
    reset_n = 1'b0;
    fetch_req = 1'b0;
    fetch_addr = '0;
    data_req = 1'b0;
    data_addr = '0;
    data_we = 1'b0;
    data_wdata = '0;
    repeat (3) step();
    check_zero("reset");
    reset_n = 1'b1;
    step();

    // both requesters from the first cycle after reset: fetch wins the tie
    t0 = cyc_cnt;
    push_load(1'b0, 64'h3000, t0 + 10, 1'b1);
    push_load(1'b1, 64'h4000, t0 + 21, 1'b1);
    fetch_req = 1'b1; fetch_addr = 64'h3000;
    data_req = 1'b1; data_addr = 64'h4000;
    wait_done(done_cnt + 1);
    fetch_req = 1'b0;
    wait_done(done_cnt + 1);
    data_req = 1'b0;
    repeat (2) step();

    // continuous simultaneous requests alternate strictly
    t0 = cyc_cnt;
    push_load(1'b0, 64'h3000, t0 + 10, 1'b1);
    push_load(1'b1, 64'h4000, t0 + 21, 1'b1);
    push_load(1'b0, 64'h3000, t0 + 32, 1'b1);
    push_load(1'b1, 64'h4000, t0 + 43, 1'b1);
    fetch_req = 1'b1;
    data_req = 1'b1;
    wait_done(done_cnt + 4);
    fetch_req = 1'b0;
    data_req = 1'b0;
    repeat (2) step();

    // single fetch, zero-wait bus
    t0 = cyc_cnt;
    push_load(1'b0, 64'h1000, t0 + 10, 1'b1);
    fetch_req = 1'b1; fetch_addr = 64'h1000;
    wait_done(done_cnt + 1);
    fetch_req = 1'b0;
    repeat (2) step();

    // store: address then data phase, done in cycle 3
    t0 = cyc_cnt;
    push_store(64'h2008, 64'hDEADBEEF, t0 + 3);
    data_req = 1'b1; data_addr = 64'h2008; data_we = 1'b1; data_wdata = 64'hDEADBEEF;
    wait_done(done_cnt + 1);
    data_req = 1'b0; data_we = 1'b0;
    repeat (2) step();

    // reqack delayed 3 cycles, response gaps after beats 2 and 5
    ack_wait = 3;
    gap_mask = 8'b0010_0100;
    t0 = cyc_cnt;
    push_load(1'b0, 64'h5000, t0 + 15, 1'b1);
    fetch_req = 1'b1; fetch_addr = 64'h5000;
    wait_done(done_cnt + 1);
    fetch_req = 1'b0;
    ack_wait = 0;
    gap_mask = 8'h00;
    repeat (2) step();

    // data_req dropped right after the grant; load still completes
    t0 = cyc_cnt;
    push_load(1'b1, 64'h6001, t0 + 10, 1'b1);
    data_req = 1'b1; data_addr = 64'h6001;
    step();
    data_req = 1'b0;
    wait_done(done_cnt + 1);
    step();
    // stray response beat while idle must be neither acked nor forwarded
    stray_req = 1'b1;
    repeat (3) step();

    // reset during beat 4 of a data load aborts with no done pulse
    last_beat = -1;
    push_load(1'b1, 64'h7000, 0, 1'b0);
    data_req = 1'b1; data_addr = 64'h7000;
    budget = 0;
    while (last_beat != 4 && budget < 50) begin
      step();
      budget++;
    end
    if (last_beat != 4) chk("beat4_timeout", 64'(last_beat), 64'd4);
    reset_n = 1'b0;
    #1;
    check_zero("abort");
    data_req = 1'b0;
    exp_beats.delete();
    exp_req.delete();
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // first request after reset starts at beat 0
    t0 = cyc_cnt;
    push_load(1'b0, 64'h8000, t0 + 10, 1'b1);
    fetch_req = 1'b1; fetch_addr = 64'h8000;
    wait_done(done_cnt + 1);
    fetch_req = 1'b0;
    repeat (3) step();

    chk("beats_left", 64'(exp_beats.size()), 64'd0);
    chk("reqs_left", 64'(exp_req.size()), 64'd0);
    chk("dones_left", 64'(exp_done.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
